// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX control slice.
//   rx_state_t      : configuration/enable FSM states
//   PRESCALE_*      : oversampling ratios the RX core supports
//   legal_prescale  : maps any requested ratio onto a supported one (default 8)
package uart_rx_pkg;

  typedef enum logic [1:0] {
    DISABLED,
    ACTIVE,
    WAIT_IDLE,
    APPLY
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through receive FIFO.
//   clk, rst   : clock, synchronous active-low reset
//   push/data  : write request; ignored when full unless a pop happens too
//   pop        : read request; ignored when empty
//   full/empty : occupancy flags
//   level      : current occupancy (0..FIFO_DEPTH)
//   rd_data    : head entry, 0 while empty
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           level,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign level   = count;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly AW bits wide, so wrap modulo depth is implicit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX control and buffering layer.
//   cfg_*          : configuration request, captured on cfg_wr
//   cfg_pending    : captured configuration not yet applied
//   rx_*  (out)    : applied configuration and enable gate to the RX core
//   rx_busy, rx_frame_end, rx_par_err, rx_stp_err, rx_p_data : RX core status
//   rd_valid/rd_ready/rd_data/fifo_level : FWFT receive FIFO read side
//   par_err_cnt, stp_err_cnt, ovf, stat_clr : saturating status, sticky overflow
//   irq            : level interrupt, FIFO at/above threshold or overflow
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned IRQ_THRESH = 4,
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic                  cfg_en,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_typ,
  input  logic [5:0]            cfg_prescale,
  output logic                  cfg_pending,
  output logic                  rx_enable,
  output logic                  rx_par_en,
  output logic                  rx_par_typ,
  output logic [5:0]            rx_prescale,
  input  logic                  rx_busy,
  input  logic                  rx_frame_end,
  input  logic                  rx_par_err,
  input  logic                  rx_stp_err,
  input  logic [DATA_WIDTH-1:0] rx_p_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LW-1:0]         fifo_level,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt,
  output logic                  ovf,
  input  logic                  stat_clr,
  output logic                  irq
);

  rx_state_t  state;
  logic       sh_en;
  logic       sh_par_en;
  logic       sh_par_typ;
  logic [5:0] sh_prescale;

  logic frame_good;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  logic overflow;

  assign frame_good = rx_frame_end & ~rx_par_err & ~rx_stp_err;
  assign rd_valid   = ~fifo_empty;
  assign fifo_pop   = rd_valid & rd_ready;
  assign overflow   = frame_good & fifo_full & ~fifo_pop;
  assign irq        = (fifo_level >= LW'(IRQ_THRESH)) | ovf;

  uart_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (frame_good),
    .push_data (rx_p_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .rd_data   (rd_data)
  );

  // Shadow is written on every cfg_wr regardless of state (last write wins);
  // APPLY reads it one edge later, so a write that coincides with leaving
  // WAIT_IDLE is the one that gets applied.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= DISABLED;
      cfg_pending <= 1'b0;
      rx_enable   <= 1'b0;
      rx_par_en   <= 1'b0;
      rx_par_typ  <= 1'b0;
      rx_prescale <= PRESCALE_8;
      sh_en       <= 1'b0;
      sh_par_en   <= 1'b0;
      sh_par_typ  <= 1'b0;
      sh_prescale <= PRESCALE_8;
    end else begin
      if (cfg_wr) begin
        sh_en       <= cfg_en;
        sh_par_en   <= cfg_par_en;
        sh_par_typ  <= cfg_par_typ;
        sh_prescale <= legal_prescale(cfg_prescale);
      end
      case (state)
        DISABLED: begin
          rx_enable <= 1'b0;
          if (cfg_wr) begin
            state       <= APPLY;
            cfg_pending <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cfg_wr) begin
            state       <= WAIT_IDLE;
            cfg_pending <= 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (!rx_busy && !rx_frame_end) begin
            state     <= APPLY;
            rx_enable <= 1'b0;
          end
        end
        APPLY: begin
          rx_par_en   <= sh_par_en;
          rx_par_typ  <= sh_par_typ;
          rx_prescale <= sh_prescale;
          if (cfg_wr) begin
            // New request during APPLY: keep the gate closed and requalify idle.
            state       <= WAIT_IDLE;
            cfg_pending <= 1'b1;
          end else begin
            state       <= sh_en ? ACTIVE : DISABLED;
            rx_enable   <= sh_en;
            cfg_pending <= 1'b0;
          end
        end
        default: begin
          state     <= DISABLED;
          rx_enable <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || stat_clr) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
      ovf         <= 1'b0;
    end else begin
      if (rx_frame_end && rx_par_err && par_err_cnt != '1)
        par_err_cnt <= par_err_cnt + 1'b1;
      if (rx_frame_end && rx_stp_err && stp_err_cnt != '1)
        stp_err_cnt <= stp_err_cnt + 1'b1;
      if (overflow)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed configuration sequences plus
// a queue-based reference model of the receive path checked by a monitor.
module tb_uart_rx_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int THR   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_wr = 1'b0, cfg_en = 1'b0, cfg_par_en = 1'b0, cfg_par_typ = 1'b0;
  logic [5:0]    cfg_prescale = '0;
  logic          cfg_pending, rx_enable, rx_par_en, rx_par_typ;
  logic [5:0]    rx_prescale;
  logic          rx_busy = 1'b0, rx_frame_end = 1'b0, rx_par_err = 1'b0, rx_stp_err = 1'b0;
  logic [DW-1:0] rx_p_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [3:0]    fifo_level;
  logic [CW-1:0] par_err_cnt, stp_err_cnt;
  logic          ovf, irq;
  logic          stat_clr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW),
    .IRQ_THRESH (THR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr       (cfg_wr),
    .cfg_en       (cfg_en),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_typ  (cfg_par_typ),
    .cfg_prescale (cfg_prescale),
    .cfg_pending  (cfg_pending),
    .rx_enable    (rx_enable),
    .rx_par_en    (rx_par_en),
    .rx_par_typ   (rx_par_typ),
    .rx_prescale  (rx_prescale),
    .rx_busy      (rx_busy),
    .rx_frame_end (rx_frame_end),
    .rx_par_err   (rx_par_err),
    .rx_stp_err   (rx_stp_err),
    .rx_p_data    (rx_p_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .fifo_level   (fifo_level),
    .par_err_cnt  (par_err_cnt),
    .stp_err_cnt  (stp_err_cnt),
    .ovf          (ovf),
    .stat_clr     (stat_clr),
    .irq          (irq)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted bytes, error totals, sticky overflow.
  byte unsigned exp_q[$];
  int  pcnt_m = 0, scnt_m = 0;
  bit  ovf_m = 0;
  bit  popped = 0;
  bit  mon_on = 0;

  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      pcnt_m = 0;
      scnt_m = 0;
      ovf_m  = 0;
    end else begin
      if (rx_frame_end) begin
        if (rx_par_err) pcnt_m = (pcnt_m == 255) ? 255 : pcnt_m + 1;
        if (rx_stp_err) scnt_m = (scnt_m == 255) ? 255 : scnt_m + 1;
        if (!rx_par_err && !rx_stp_err) begin
          // exp_q already reflects this cycle's pop, so it is full only if none happened.
          if (exp_q.size() >= DEPTH) ovf_m = 1;
          else exp_q.push_back(rx_p_data);
        end
      end
      if (stat_clr) begin
        pcnt_m = 0;
        scnt_m = 0;
        ovf_m  = 0;
      end
    end
    popped = 0;
  end

  // Monitor: compares observable receive-path state and consumes popped bytes.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("rd_valid", rd_valid, exp_q.size() != 0);
      chk("fifo_level", fifo_level, exp_q.size());
      chk("par_err_cnt", par_err_cnt, pcnt_m);
      chk("stp_err_cnt", stp_err_cnt, scnt_m);
      chk("ovf", ovf, ovf_m);
      chk("irq", irq, (exp_q.size() >= THR) || ovf_m);
      if (exp_q.size() == 0) begin
        chk("rd_data_empty", rd_data, 0);
      end else if (rd_ready) begin
        chk("rd_data", rd_data, exp_q[0]);
        void'(exp_q.pop_front());
        popped = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [DW-1:0] d, input bit p, input bit s);
    rx_frame_end = 1'b1;
    rx_p_data    = d;
    rx_par_err   = p;
    rx_stp_err   = s;
    tick();
    rx_frame_end = 1'b0;
    rx_par_err   = 1'b0;
    rx_stp_err   = 1'b0;
  endtask

  task automatic cfg(input bit en, input bit pe, input bit pt, input logic [5:0] ps);
    cfg_en       = en;
    cfg_par_en   = pe;
    cfg_par_typ  = pt;
    cfg_prescale = ps;
    cfg_wr       = 1'b1;
    tick();
    cfg_wr       = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_rx_enable", rx_enable, 0);
    chk("rst_rx_prescale", rx_prescale, 8);
    chk("rst_rx_par_en", rx_par_en, 0);
    chk("rst_rx_par_typ", rx_par_typ, 0);
    chk("rst_cfg_pending", cfg_pending, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_par_cnt", par_err_cnt, 0);
    chk("rst_stp_cnt", stp_err_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_irq", irq, 0);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    tick();
    tick();
    chk_reset_values();
    mon_on = 1;
    rst = 1'b1;

    // Configuration applied from DISABLED
    cfg(1, 1, 1, 6'd16);
    chk("idle_pending", cfg_pending, 1);
    chk("idle_en_in_apply", rx_enable, 0);
    chk("idle_ps_before", rx_prescale, 8);
    tick();
    chk("idle_pending_clr", cfg_pending, 0);
    chk("idle_en", rx_enable, 1);
    chk("idle_ps", rx_prescale, 16);
    chk("idle_par_en", rx_par_en, 1);
    chk("idle_par_typ", rx_par_typ, 1);

    // Deferral while a frame is in progress
    rx_busy = 1'b1;
    cfg(1, 0, 0, 6'd32);
    for (int i = 0; i < 20; i++) begin
      chk("defer_pending", cfg_pending, 1);
      chk("defer_en", rx_enable, 1);
      chk("defer_ps", rx_prescale, 16);
      chk("defer_par_en", rx_par_en, 1);
      tick();
    end
    rx_busy = 1'b0;
    tick();
    chk("defer_apply_en", rx_enable, 0);
    chk("defer_apply_pending", cfg_pending, 1);
    chk("defer_apply_ps", rx_prescale, 16);
    tick();
    chk("defer_done_en", rx_enable, 1);
    chk("defer_done_ps", rx_prescale, 32);
    chk("defer_done_par_en", rx_par_en, 0);
    chk("defer_done_pending", cfg_pending, 0);

    // Unsupported prescale falls back to 8
    cfg(1, 1, 0, 6'd12);
    tick();
    tick();
    chk("illegal_ps", rx_prescale, 8);
    chk("illegal_par_en", rx_par_en, 1);

    // A frame_end in the idle-check cycle holds the wait
    cfg(1, 0, 1, 6'd16);
    frame(8'h5A, 0, 0);
    chk("fe_hold_en", rx_enable, 1);
    chk("fe_hold_pending", cfg_pending, 1);
    tick();
    chk("fe_apply_en", rx_enable, 0);
    tick();
    chk("fe_done_ps", rx_prescale, 16);
    chk("fe_done_typ", rx_par_typ, 1);
    chk("fe_done_en", rx_enable, 1);

    // Disable then re-enable
    cfg(0, 0, 0, 6'd32);
    tick();
    tick();
    chk("dis_en", rx_enable, 0);
    chk("dis_ps", rx_prescale, 32);
    tick();
    chk("dis_en_hold", rx_enable, 0);
    cfg(1, 0, 0, 6'd8);
    tick();
    chk("reen_en", rx_enable, 1);

    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;

    // Good frames, threshold boundary, in-order drain
    frame(8'h55, 0, 0);
    frame(8'hA3, 0, 0);
    frame(8'h00, 0, 0);
    chk("good_level3", fifo_level, 3);
    chk("good_irq3", irq, 0);
    frame(8'hFF, 0, 0);
    chk("good_level4", fifo_level, 4);
    chk("good_irq4", irq, 1);
    chk("good_head", rd_data, 8'h55);
    rd_ready = 1'b1;
    repeat (5) tick();
    rd_ready = 1'b0;
    chk("good_drained", rd_valid, 0);

    // Error frames and counter saturation
    frame(8'h11, 1, 0);
    frame(8'h22, 0, 1);
    frame(8'h33, 1, 1);
    chk("err_par", par_err_cnt, 2);
    chk("err_stp", stp_err_cnt, 2);
    chk("err_level", fifo_level, 0);
    repeat (300) frame(DW'($urandom), 1, 0);
    chk("sat_par", par_err_cnt, 255);
    chk("sat_stp", stp_err_cnt, 2);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_par", par_err_cnt, 0);

    // Overflow, push+pop when full, clear keeps FIFO
    for (int i = 0; i < 9; i++) frame(DW'($urandom), 0, 0);
    chk("ovf_set", ovf, 1);
    chk("ovf_level", fifo_level, 8);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    chk("ovf_clr_level", fifo_level, 8);
    rd_ready = 1'b1;
    frame(8'hC3, 0, 0);
    rd_ready = 1'b0;
    chk("full_pushpop_ovf", ovf, 0);
    chk("full_pushpop_level", fifo_level, 8);
    stat_clr = 1'b1;
    frame(8'h3C, 0, 0);
    stat_clr = 1'b0;
    chk("clr_beats_ovf", ovf, 0);
    rd_ready = 1'b1;
    repeat (10) tick();
    rd_ready = 1'b0;

    // Randomized receive traffic
    for (int i = 0; i < 1500; i++) begin
      rx_frame_end = 1'($urandom_range(0, 1));
      rx_p_data    = DW'($urandom);
      rx_par_err   = ($urandom_range(0, 3) == 0);
      rx_stp_err   = ($urandom_range(0, 3) == 0);
      rd_ready     = ($urandom_range(0, 2) == 0);
      stat_clr     = ($urandom_range(0, 31) == 0);
      rx_busy      = 1'($urandom_range(0, 1));
      tick();
    end
    rx_frame_end = 1'b0;
    rx_par_err   = 1'b0;
    rx_stp_err   = 1'b0;
    stat_clr     = 1'b0;
    rx_busy      = 1'b0;
    rd_ready     = 1'b1;
    repeat (10) tick();
    rd_ready = 1'b0;

    // Reset with queued data and a pending configuration
    frame(8'h01, 0, 0);
    frame(8'h02, 0, 0);
    frame(8'h03, 0, 0);
    rx_busy = 1'b1;
    cfg(1, 1, 1, 6'd32);
    chk("pre_rst_pending", cfg_pending, 1);
    chk("pre_rst_level", fifo_level, 3);
    rst = 1'b0;
    tick();
    chk_reset_values();
    rst = 1'b1;
    rx_busy = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
